// File: rtl/sev_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// sev_segment_scan_driver
//
// Time-multiplexed driver for a bank of common-segment seven-segment digits.
// A packed vector of 4-bit digit codes plus decimal points is captured into a
// shadow buffer on `load`. It is promoted to the active buffer only when the
// scan wraps back to digit 0, so a frame never shows a mix of old and new data.
// One digit is scanned per slot of SCAN_DIV cycles. All digit enables are held
// off for the first BLANK_CYC cycles of each slot to suppress ghosting.
//
// Optional feature macro: SEVSEG_HEX_EN
//   defined   : codes 10..15 decode to A b C d E F
//   undefined : codes 10..15 decode to a blank digit (dp still driven)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   load       in   one-cycle strobe, captures bcd_in/dp_in into the shadow
//   bcd_in     in   [4*NUM_DIGITS-1:0] digit codes, digit 0 in bits [3:0]
//   dp_in      in   [NUM_DIGITS-1:0] decimal point per digit
//   blank_lz   in   leading-zero blanking enable (level)
//   seg        out  [6:0] segments {a,b,c,d,e,f,g}, polarity per SEG_ACTIVE_LOW
//   dp         out  decimal point of the scanned digit, polarity per SEG_ACTIVE_LOW
//   an         out  [NUM_DIGITS-1:0] one-hot digit enable, polarity per AN_ACTIVE_LOW
//   frame_tick out  one-cycle pulse at the start of each frame
//
// Handshake: `load` is a plain strobe with no backpressure. Every cycle it is
// high, the inputs are captured; the last capture before a wrap is the one shown.
// -----------------------------------------------------------------------------
module sev_segment_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int PCNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_bcd_q, active_bcd_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_end;
  logic                    wrap;
  logic                    blank_win;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    zeros_above;
  logic [NUM_DIGITS-1:0]   lz_mask;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
`ifdef SEVSEG_HEX_EN
      4'd10:   s = 7'b1110111;
      4'd11:   s = 7'b0011111;
      4'd12:   s = 7'b1001110;
      4'd13:   s = 7'b0111101;
      4'd14:   s = 7'b1001111;
      4'd15:   s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // The enable-off window disappears entirely when BLANK_CYC is 0.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_win = 1'b0;
    end else begin : g_blank
      assign blank_win = (pcnt_q < PCNT_W'(BLANK_CYC));
    end
  endgenerate

  assign slot_end = (pcnt_q == PCNT_W'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    cur_code    = 4'd0;
    cur_dp      = 1'b0;
    cur_lz      = 1'b0;
    lz_mask     = '0;
    zeros_above = 1'b1;

    // A digit is a leading zero when it and every digit above it are 0.
    // Digit 0 is always shown so a zero value still displays "0".
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      zeros_above = zeros_above & (active_bcd_q[4*j +: 4] == 4'd0);
      lz_mask[j]  = zeros_above && (j != 0);
    end

    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        cur_code = active_bcd_q[4*j +: 4];
        cur_dp   = active_dp_q[j];
        cur_lz   = lz_mask[j];
      end
    end
  end

  always_comb begin
    pcnt_d       = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d        = idx_q;
    active_bcd_d = active_bcd_q;
    active_dp_d  = active_dp_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Promotion uses the shadow as it was before this cycle's load, and a
    // load landing on the wrap cycle stays pending for the following frame.
    if (wrap && pending_q) begin
      active_bcd_d = shadow_bcd_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    // Outputs are computed from the current scan position and registered,
    // so the pins trail the counters by exactly one cycle.
    seg_d        = (blank_lz && cur_lz) ? 7'b0000000 : decode(cur_code);
    dp_d         = cur_dp;
    an_d         = blank_win ? '0 : (NUM_DIGITS'(1) << idx_q);
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      active_bcd_q <= '0;
      active_dp_q  <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'b0000000;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      active_bcd_q <= active_bcd_d;
      active_dp_q  <= active_dp_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Pin polarity is applied after the logical registers.
  assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp         = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign an         = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sev_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sev_segment_scan_driver
//
// Directed bench for sev_segment_scan_driver with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYC=1 and active-high pins. `cyc` counts rising edges since the last
// reset release. The output seen after edge c shows scan position c-1:
// slot pcnt = (c-1)%8 and digit ((c-1)/8)%4. A frame ends on edges c = 32k.
// -----------------------------------------------------------------------------
module tb_sev_segment_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SX = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  sev_segment_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    load   = 1'b1;
    bcd_in = b;
    dp_in  = d;
    step();
    load   = 1'b0;
    bcd_in = 16'hFFFF;
    dp_in  = 4'hF;
  endtask

  // ---------------- expected scan timing ----------------
  function automatic int dig_of(input int c);
    return ((c - 1) / 8) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int c);
    if (((c - 1) % 8) < 1) return 4'b0000;
    return 4'b0001 << dig_of(c);
  endfunction

  function automatic logic exp_ft(input int c);
    return (c % 32) == 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (seg !== SX) begin n_err++; $display("FAIL reset_seg got=%b want=%b", seg, SX); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL reset_dp got=%b want=0", dp); end
    n_cmp++; if (an !== 4'b0000) begin n_err++; $display("FAIL reset_an got=%b want=0000", an); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_ft got=%b want=0", frame_tick); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_scan();
    while (cyc < 40) begin
      step();
      n_cmp++; if (seg !== S0) begin n_err++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", cyc, seg, S0); end
      n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL scan_dp cyc=%0d got=%b want=0", cyc, dp); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL scan_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (frame_tick !== exp_ft(cyc)) begin n_err++; $display("FAIL scan_ft cyc=%0d got=%b want=%b", cyc, frame_tick, exp_ft(cyc)); end
    end
  endtask

  task automatic test_load_mid_frame();
    logic [6:0] tbl [4];
    logic [6:0] es;
    logic       ed;
    tbl = '{S4, S3, S2, S1};
    do_load(16'h1234, 4'b0100);
    while (cyc < 96) begin
      step();
      es = (cyc <= 64) ? S0 : tbl[dig_of(cyc)];
      ed = (cyc <= 64) ? 1'b0 : (dig_of(cyc) == 2);
      n_cmp++; if (seg !== es) begin n_err++; $display("FAIL load_seg cyc=%0d got=%b want=%b", cyc, seg, es); end
      n_cmp++; if (dp !== ed) begin n_err++; $display("FAIL load_dp cyc=%0d got=%b want=%b", cyc, dp, ed); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL load_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (frame_tick !== exp_ft(cyc)) begin n_err++; $display("FAIL load_ft cyc=%0d got=%b want=%b", cyc, frame_tick, exp_ft(cyc)); end
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] tbl_on [4];
    logic [6:0] tbl_off [4];
    logic [6:0] es;
    tbl_on  = '{S0, S7, SX, SX};
    tbl_off = '{S0, S7, S0, S0};
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    run_to(128);
    while (cyc < 192) begin
      step();
      es = (cyc <= 160) ? tbl_on[dig_of(cyc)] : tbl_off[dig_of(cyc)];
      n_cmp++; if (seg !== es) begin n_err++; $display("FAIL lz_seg cyc=%0d got=%b want=%b", cyc, seg, es); end
      n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL lz_dp cyc=%0d got=%b want=0", cyc, dp); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL lz_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
      if (cyc == 160) blank_lz = 1'b0;
    end
  endtask

  task automatic test_hex();
    logic [6:0] tbl [4];
    logic [6:0] es;
    logic       ed;
`ifdef SEVSEG_HEX_EN
    tbl = '{7'b1000111, 7'b1001110, 7'b0011111, 7'b1110111};
`else
    tbl = '{SX, SX, SX, SX};
`endif
    do_load(16'hABCF, 4'b0001);
    run_to(224);
    while (cyc < 256) begin
      step();
      es = tbl[dig_of(cyc)];
      ed = (dig_of(cyc) == 0);
      n_cmp++; if (seg !== es) begin n_err++; $display("FAIL hex_seg cyc=%0d got=%b want=%b", cyc, seg, es); end
      n_cmp++; if (dp !== ed) begin n_err++; $display("FAIL hex_dp cyc=%0d got=%b want=%b", cyc, dp, ed); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL hex_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] es;
    do_load(16'h5555, 4'b0000);
    run_to(287);
    // This load is captured on edge 288, the same edge that wraps the scan.
    do_load(16'h9999, 4'b0000);
    while (cyc < 352) begin
      step();
      es = (cyc <= 320) ? S5 : S9;
      n_cmp++; if (seg !== es) begin n_err++; $display("FAIL b2b_seg cyc=%0d got=%b want=%b", cyc, seg, es); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL b2b_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (frame_tick !== exp_ft(cyc)) begin n_err++; $display("FAIL b2b_ft cyc=%0d got=%b want=%b", cyc, frame_tick, exp_ft(cyc)); end
    end
  endtask

  task automatic test_reset_mid();
    do_load(16'h8888, 4'b1111);
    run_to(356);
    rst = 1'b1;
    step();
    n_cmp++; if (seg !== SX) begin n_err++; $display("FAIL rmid_seg got=%b want=%b", seg, SX); end
    n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL rmid_dp got=%b want=0", dp); end
    n_cmp++; if (an !== 4'b0000) begin n_err++; $display("FAIL rmid_an got=%b want=0000", an); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rmid_ft got=%b want=0", frame_tick); end
    rst = 1'b0;
    cyc = 0;
    while (cyc < 66) begin
      step();
      n_cmp++; if (seg !== S0) begin n_err++; $display("FAIL rpost_seg cyc=%0d got=%b want=%b", cyc, seg, S0); end
      n_cmp++; if (dp !== 1'b0) begin n_err++; $display("FAIL rpost_dp cyc=%0d got=%b want=0", cyc, dp); end
      n_cmp++; if (an !== exp_an(cyc)) begin n_err++; $display("FAIL rpost_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc)); end
      n_cmp++; if (frame_tick !== exp_ft(cyc)) begin n_err++; $display("FAIL rpost_ft cyc=%0d got=%b want=%b", cyc, frame_tick, exp_ft(cyc)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_blank_lz();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sev_segment_scan_driver.md
# sev_segment_scan_driver

Time-multiplexed driver for a bank of common-segment seven-segment digits, the parametrised successor to the single-digit BCD decoder. It latches a packed vector of 4-bit digit codes and decimal points, scans one digit per slot with a programmable prescaler, and drives shared segment lines plus one enable per digit. It sits between the numeric datapath (counters, measurement blocks) and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 1–8.
- SCAN_DIV, 1000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 2, cycles at slot start with all digit enables off (anti-ghosting); 0 ≤ BLANK_CYC < SCAN_DIV.
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 0, 1 inverts an at the pins.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures bcd_in/dp_in into the shadow registers.
- bcd_in  in  4*NUM_DIGITS  digit codes; bits [4i+3:4i] = digit i, digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  leading-zero blanking enable, level-sensitive.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB; "on" = 1 before polarity.
- dp  out  1  decimal point of the digit currently scanned.
- an  out  NUM_DIGITS  one-hot digit enable.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. Digit index idx advances when pcnt = SCAN_DIV-1; it wraps from NUM_DIGITS-1 to 0.
- Shadow/active double buffer. load writes shadow and sets pending. On idx wrap to 0 with pending set, shadow is copied to active and pending is cleared. A load in the same cycle as the wrap updates shadow and keeps pending set; the copy uses the pre-load shadow. When multiple loads arrive before a wrap, the last one wins.
- Decode of active digit idx, same cycle as the index registers:
  - 0..9 → 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - 10..15 → see Configuration.
- Leading-zero blanking: with blank_lz = 1, scanning from digit NUM_DIGITS-1 downward, every digit whose code is 0 and has only zeros above it outputs seg = 0000000. Digit 0 is never blanked. dp is unaffected by blanking.
- an: bit idx on, except while pcnt < BLANK_CYC, when all enables are off. seg and dp keep their values during the blank window.
- frame_tick is high for the cycle after idx becomes 0.

## Timing
- All outputs are registered and reflect pcnt/idx state from the previous cycle, giving 1 cycle of output latency.
- Slot length is SCAN_DIV cycles; frame length is NUM_DIGITS*SCAN_DIV cycles.
- Latency from load to visible: the copy happens at the next wrap, and the value appears on the pins 1 cycle later. Worst case is one frame + 1 cycle.
- Reset (any cycle, including mid-scan or with pending set):
  - Internal: pcnt = 0, idx = 0, active = 0, shadow = 0, pending = 0.
  - Outputs: seg = 0000000, dp = 0, an all off, frame_tick = 0. These are logical levels; polarity parameters are applied after them.
- After reset release, digit 0 is enabled at cycle BLANK_CYC+1, showing 0 (1111110).
- NUM_DIGITS = 1: idx is constant 0, and frame_tick pulses every SCAN_DIV cycles.

## Configuration
- SEVSEG_HEX_EN defined: codes 10–15 decode to A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- SEVSEG_HEX_EN undefined: codes 10–15 decode to 0000000 (blank); dp is still driven.

## Test plan
Bench parameters: NUM_DIGITS = 4, SCAN_DIV = 8, BLANK_CYC = 1, polarity 0.
- Reset, then run 40 cycles → frame_tick pulses every 32 cycles. an goes 0000 for 1 cycle, then 0001 for 7 cycles, then 0010, and so on. seg = 1111110 throughout.
- load with bcd_in = 16'h1234 and dp_in = 4'b0100 mid-frame → display is unchanged until the wrap. The next frame shows digit0 1011011? No: digit0 = 4 → 0110011, digit1 = 3 → 1111001, digit2 = 2 → 1101101 with dp = 1, digit3 = 1 → 0110000.
- bcd_in = 16'h0070 with blank_lz = 1 → digits 3 and 2 show 0000000, digit 1 shows 1110000, and digit 0 shows 1111110. With blank_lz = 0, all four digits are shown.
- bcd_in = 16'hABCF → with SEVSEG_HEX_EN, digit 0 shows 1000111. Without it, every digit shows 0000000.
- load on the exact wrap cycle with 16'h9999, after a prior pending 16'h5555 → next frame shows 5555, and the frame after shows 9999.
- Assert rst for 1 cycle mid-slot with pending set → outputs return to reset values on the next cycle, and the pending data is never displayed.
